// File: rtl/mem_burst_pkg.sv
// Shared state encoding, memory geometry and bank helper for the burst master slice.
package mem_burst_pkg;
  localparam int MEM_DEPTH = 4096;
  localparam int BANK_BITS = 2;
  localparam int ADDR_W    = $clog2(MEM_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  function automatic logic [BANK_BITS-1:0] bank_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: BANK_BITS];
  endfunction
endpackage

// File: rtl/mem_burst_rbuf.sv
// Two-entry read-data FIFO with a last-beat sideband; occupancy feeds read-issue gating.
module mem_burst_rbuf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_push_last,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic [1:0]            o_count
);
  logic [DATA_WIDTH-1:0] r_data [2];
  logic [1:0]            r_last;
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;
  logic                  w_pop;

  assign w_pop = i_pop && (r_count != 2'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
      r_last  <= 2'b00;
    end else begin
      if (i_push) begin
        r_wptr         <= ~r_wptr;
        r_last[r_wptr] <= i_push_last;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (i_push) r_data[r_wptr] <= i_push_data;
  end

  // Empty FIFO presents zeros so stale words never leak onto the stream.
  assign o_valid = (r_count != 2'd0);
  assign o_data  = o_valid ? r_data[r_rptr] : '0;
  assign o_last  = o_valid && r_last[r_rptr];
  assign o_count = r_count;
endmodule

// File: rtl/mem_burst_master.sv
// Burst access engine for the banked 4096x32 SRAM wrapper. Define MEM_BURST_WRAP_EN to let
// bursts wrap past the top address instead of rejecting out-of-range commands.
module mem_burst_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int BANK_BITS  = 2,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wdat_valid,
  output logic                  wdat_ready,
  input  logic [DATA_WIDTH-1:0] wdat_data,
  output logic                  rdat_valid,
  input  logic                  rdat_ready,
  output logic [DATA_WIDTH-1:0] rdat_data,
  output logic                  rdat_last,
  output logic                  done,
  output logic                  err,
  output logic                  mem_chip_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);
  import mem_burst_pkg::*;

  localparam logic [LEN_WIDTH:0]    REM_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cur;
  logic [LEN_WIDTH:0]    r_rem;
  logic                  r_infl;
  logic [ADDR_WIDTH-1:0] r_infl_addr;
  logic                  r_infl_last;
  logic                  r_done;
  logic                  r_err;

  logic       w_accept;
  logic       w_range_bad;
  logic       w_wbeat;
  logic       w_issue;
  logic       w_pop;
  logic       w_same_bank;
  logic [1:0] w_count;
  logic [2:0] w_free;

`ifdef MEM_BURST_WRAP_EN
  assign w_range_bad = 1'b0;
`else
  logic [ADDR_WIDTH:0] w_end;
  assign w_end       = {1'b0, cmd_addr} + (ADDR_WIDTH+1)'(cmd_len);
  assign w_range_bad = w_end[ADDR_WIDTH];
`endif

  assign cmd_ready   = (r_state == IDLE) && !reset;
  assign w_accept    = cmd_valid && cmd_ready;
  assign wdat_ready  = (r_state == WRITE);
  assign w_wbeat     = wdat_ready && wdat_valid;
  assign w_pop       = rdat_valid && rdat_ready;
  assign w_same_bank = (r_cur[ADDR_WIDTH-1 -: BANK_BITS] == r_infl_addr[ADDR_WIDTH-1 -: BANK_BITS]);
  // A beat leaving this cycle frees its slot in time for the next capture, which keeps same-bank reads at full rate.
  assign w_free  = 3'd2 - {1'b0, w_count} + {2'b00, w_pop};
  assign w_issue = (r_state == READ) && (r_rem != '0) && (w_free > {2'b00, r_infl}) &&
                   (!r_infl || w_same_bank);
  assign done = r_done;
  assign err  = r_err;

  always_comb begin
    mem_chip_en = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    if (w_wbeat) begin
      mem_chip_en = 1'b1;
      mem_wr_en   = 1'b1;
      mem_addr    = r_cur;
      mem_wr_data = wdat_data;
    end else if (w_issue) begin
      mem_chip_en = 1'b1;
      mem_rd_en   = 1'b1;
      mem_addr    = r_cur;
    end else if (r_infl) begin
      // Capture-only cycle: hold the in-flight address so its bank stays selected in the read mux.
      mem_chip_en = 1'b1;
      mem_addr    = r_infl_addr;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cur       <= '0;
      r_rem       <= '0;
      r_infl      <= 1'b0;
      r_infl_addr <= '0;
      r_infl_last <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_infl <= w_issue;
      if (w_issue) begin
        r_infl_addr <= r_cur;
        r_infl_last <= (r_rem == REM_ONE);
      end
      case (r_state)
        IDLE: if (w_accept) begin
          if (w_range_bad) r_err <= 1'b1;
          else begin
            r_cur   <= cmd_addr;
            r_rem   <= (LEN_WIDTH+1)'(cmd_len) + REM_ONE;
            r_state <= cmd_write ? WRITE : READ;
          end
        end
        WRITE: if (wdat_valid) begin
          r_cur <= r_cur + ADDR_ONE;
          r_rem <= r_rem - REM_ONE;
          if (r_rem == REM_ONE) begin
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
        end
        READ: if (w_issue) begin
          r_cur <= r_cur + ADDR_ONE;
          r_rem <= r_rem - REM_ONE;
          if (r_rem == REM_ONE) r_state <= DRAIN;
        end
        DRAIN: if (w_pop && rdat_last) begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  mem_burst_rbuf #(.DATA_WIDTH(DATA_WIDTH)) u_rbuf (
    .clock       (clock),
    .reset       (reset),
    .i_push      (r_infl),
    .i_push_data (mem_rd_data),
    .i_push_last (r_infl_last),
    .i_pop       (w_pop),
    .o_valid     (rdat_valid),
    .o_data      (rdat_data),
    .o_last      (rdat_last),
    .o_count     (w_count)
  );
endmodule

// File: tb/tb_mem_burst_master.sv
// Randomized bench for mem_burst_master: banked SRAM model, burst-level scoreboard, directed timing pins.
module tb_mem_burst_master;
  import mem_burst_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        wdat_valid, wdat_ready;
  logic [31:0] wdat_data;
  logic        rdat_valid, rdat_ready, rdat_last;
  logic [31:0] rdat_data;
  logic        done, err;
  logic        mem_chip_en, mem_rd_en, mem_wr_en;
  logic [11:0] mem_addr;
  logic [31:0] mem_wr_data, mem_rd_data;

  mem_burst_master dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat_data(wdat_data),
    .rdat_valid(rdat_valid), .rdat_ready(rdat_ready), .rdat_data(rdat_data), .rdat_last(rdat_last),
    .done(done), .err(err),
    .mem_chip_en(mem_chip_en), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clock = ~clock;

  int n_vec = 0, n_err = 0;
  int done_cnt = 0, err_cnt = 0, exp_done = 0, exp_err = 0;
  int wmode = 0, rmode = 0;
  logic [31:0] wq [$];
  logic [11:0] exp_wa [$];
  logic [31:0] exp_wd [$];
  logic [31:0] exp_rd [$];
  logic        exp_rl [$];
  logic [31:0] ref_mem [4096];
  bit          written [4096];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // Banked SRAM: read data is only driven while the addressed bank still matches the issuing bank.
  logic [31:0] sram [4096];
  logic        pend;
  logic [11:0] pend_addr;
  logic [31:0] garbage;
  always @(posedge clock) begin
    garbage   <= $urandom;
    pend      <= mem_chip_en && mem_rd_en;
    pend_addr <= mem_addr;
    if (mem_chip_en && mem_wr_en) sram[mem_addr] <= mem_wr_data;
  end
  assign mem_rd_data = (pend && mem_chip_en && bank_of(mem_addr) == bank_of(pend_addr)) ?
                       sram[pend_addr] : garbage;

  initial begin : wdrv
    bit hs;
    wdat_valid = 1'b0;
    wdat_data  = '0;
    forever begin
      @(negedge clock);
      hs = wdat_valid && wdat_ready;
      @(posedge clock); #1;
      if (hs && wq.size() > 0) void'(wq.pop_front());
      if (wq.size() > 0 && (wmode == 0 || $urandom_range(1, 0) == 1)) begin
        wdat_valid = 1'b1;
        wdat_data  = wq[0];
      end else wdat_valid = 1'b0;
    end
  end

  initial begin : rdrv
    rdat_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      case (rmode)
        0:       rdat_ready = 1'b1;
        1:       rdat_ready = ~rdat_ready;
        default: rdat_ready = ($urandom_range(1, 0) == 1);
      endcase
    end
  end

  initial begin : mon
    int outst;
    outst = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        outst = 0;
      end else begin
        if (mem_rd_en && mem_wr_en) chk("rd_wr_exclusive", 32'd1, 32'd0);
        if ((mem_rd_en || mem_wr_en) && !mem_chip_en) chk("strobe_without_chip_en", 32'd1, 32'd0);
        if (mem_rd_en) chk("inflight_plus_buffered_le2", 32'(outst <= 2), 32'd1);
        if (mem_wr_en) begin
          if (exp_wa.size() == 0) chk("unexpected_write_addr", 32'(mem_addr), 32'hFFFFFFFF);
          else begin
            chk("write_addr", 32'(mem_addr), 32'(exp_wa.pop_front()));
            chk("write_data", mem_wr_data, exp_wd.pop_front());
          end
        end
        if (rdat_valid && rdat_ready) begin
          if (exp_rd.size() == 0) chk("unexpected_read_beat", rdat_data, 32'hFFFFFFFF);
          else begin
            chk("read_data", rdat_data, exp_rd.pop_front());
            chk("read_last", 32'(rdat_last), 32'(exp_rl.pop_front()));
          end
        end
        if (done && err) chk("done_err_together", 32'd1, 32'd0);
        if (done) done_cnt++;
        if (err) err_cnt++;
        outst = outst + int'(mem_chip_en && mem_rd_en) - int'(rdat_valid && rdat_ready);
      end
    end
  end

  function automatic bit out_of_range(input int addr, input int len);
`ifdef MEM_BURST_WRAP_EN
    return 1'b0;
`else
    return (addr + len) > 4095;
`endif
  endfunction

  // Expected effects of one command, derived from address/length alone.
  task automatic model_cmd(input bit wr, input int addr, input int len, input bit directed);
    logic [31:0] d;
    int a;
    if (out_of_range(addr, len)) begin
      exp_err++;
      return;
    end
    for (int i = 0; i <= len; i++) begin
      a = (addr + i) % 4096;
      if (wr) begin
        d = directed ? 32'hA5A50000 + 32'(i) : $urandom;
        wq.push_back(d);
        exp_wa.push_back(12'(a));
        exp_wd.push_back(d);
        ref_mem[a] = d;
        written[a] = 1'b1;
      end else begin
        exp_rd.push_back(ref_mem[a]);
        exp_rl.push_back(i == len);
      end
    end
    exp_done++;
  endtask

  task automatic send_cmd(input bit wr, input int addr, input int len);
    @(posedge clock); #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr[11:0];
    cmd_len   = len[7:0];
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (cmd_ready) break;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", 32'(cmd_ready), 32'd1);
    @(posedge clock); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_quiet();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clock);
      if (done_cnt == exp_done && err_cnt == exp_err) break;
    end
    chk("burst_complete", 32'(done_cnt == exp_done && err_cnt == exp_err), 32'd1);
    chk("write_beats_outstanding", 32'(exp_wa.size()), 32'd0);
    chk("read_beats_outstanding", 32'(exp_rd.size()), 32'd0);
  endtask

  task automatic run_cmd(input bit wr, input int addr, input int len);
    model_cmd(wr, addr, len, 1'b0);
    send_cmd(wr, addr, len);
    wait_quiet();
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    int a, l, base;
    bit wr, ok;
    logic [11:0] wrap_addr [4];
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    repeat (2) @(negedge clock);
    chk("reset_chip_en", 32'(mem_chip_en), 32'd0);
    chk("reset_rdat_valid", 32'(rdat_valid), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    #2 reset = 1'b0;
    @(negedge clock);
    chk("cmd_ready_after_reset", 32'(cmd_ready), 32'd1);

    // 4-beat write at 0x010, continuous data
    wmode = 0; rmode = 0;
    model_cmd(1'b1, 'h010, 3, 1'b1);
    chk("model_ref_mem_0x013", ref_mem[12'h013], 32'hA5A50003);
    send_cmd(1'b1, 'h010, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("wr4_wr_en", 32'(mem_wr_en), 32'd1);
      chk("wr4_addr", 32'(mem_addr), 32'h10 + 32'(i));
    end
    @(negedge clock);
    chk("wr4_done", 32'(done), 32'd1);
    wait_quiet();

    // 4-beat read back at 0x010, full-rate
    model_cmd(1'b0, 'h010, 3, 1'b0);
    chk("model_rd4_beat3", exp_rd[3], 32'hA5A50003);
    chk("model_rd4_last", 32'(exp_rl[3]), 32'd1);
    send_cmd(1'b0, 'h010, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("rd4_rd_en", 32'(mem_rd_en), 32'd1);
      chk("rd4_addr", 32'(mem_addr), 32'h10 + 32'(i));
    end
    wait_quiet();

    // Bank 0 -> 1 crossing
    wmode = 1;
    run_cmd(1'b1, 'h3FC, 7);
    model_cmd(1'b0, 'h3FF, 1, 1'b0);
    send_cmd(1'b0, 'h3FF, 1);
    @(negedge clock);
    chk("xbank_issue0_rd_en", 32'(mem_rd_en), 32'd1);
    chk("xbank_issue0_addr", 32'(mem_addr), 32'h3FF);
    @(negedge clock);
    chk("xbank_bubble_chip_en", 32'(mem_chip_en), 32'd1);
    chk("xbank_bubble_rd_en", 32'(mem_rd_en), 32'd0);
    chk("xbank_bubble_addr", 32'(mem_addr), 32'h3FF);
    @(negedge clock);
    chk("xbank_issue1_rd_en", 32'(mem_rd_en), 32'd1);
    chk("xbank_issue1_addr", 32'(mem_addr), 32'h400);
    wait_quiet();

    // 8 beats with toggling backpressure
    rmode = 1;
    run_cmd(1'b0, 'h3FC, 7);

    // Burst reaching past the top address
    wmode = 0; rmode = 0;
`ifdef MEM_BURST_WRAP_EN
    wrap_addr[0] = 12'hFFE; wrap_addr[1] = 12'hFFF; wrap_addr[2] = 12'h000; wrap_addr[3] = 12'h001;
    model_cmd(1'b1, 'hFFE, 3, 1'b0);
    send_cmd(1'b1, 'hFFE, 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("wrap_wr_en", 32'(mem_wr_en), 32'd1);
      chk("wrap_addr", 32'(mem_addr), 32'(wrap_addr[i]));
    end
    wait_quiet();
    run_cmd(1'b0, 'hFFE, 3);
`else
    wrap_addr[0] = 12'h000;
    for (int i = 0; i < 4; i++) wq.push_back(32'hDEAD0000 + 32'(i));
    model_cmd(1'b1, 'hFFE, 3, 1'b0);
    send_cmd(1'b1, 'hFFE, 3);
    @(negedge clock);
    chk("range_err_pulse", 32'(err), 32'd1);
    chk("range_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("range_no_chip_en", 32'(mem_chip_en), 32'(wrap_addr[0]));
    @(negedge clock);
    chk("range_err_single", 32'(err), 32'd0);
    chk("range_no_beats_taken", 32'(wq.size()), 32'd4);
    wq.delete();
    wait_quiet();
`endif

    // Randomized bursts around bank edges
    for (int k = 0; k < 40; k++) begin
      wmode = $urandom_range(1, 0);
      rmode = $urandom_range(2, 0);
      wr    = ($urandom_range(1, 0) == 1);
      case ($urandom_range(4, 0))
        0:       base = 'h000;
        1:       base = 'h3F0;
        2:       base = 'h7F0;
        3:       base = 'hBF0;
        default: base = 'hFE0;
      endcase
      a = base + $urandom_range(31, 0);
      l = $urandom_range(31, 0);
      if (!wr && !out_of_range(a, l)) begin
        ok = 1'b1;
        for (int i = 0; i <= l; i++) if (!written[(a + i) % 4096]) ok = 1'b0;
        if (!ok) begin a = 'h3FC; l = 7; end
      end
      run_cmd(wr, a, l);
    end

    // Reset during the third issue of an 8-beat read
    wmode = 0; rmode = 0;
    model_cmd(1'b0, 'h3FC, 7, 1'b0);
    send_cmd(1'b0, 'h3FC, 7);
    repeat (2) @(negedge clock);
    @(negedge clock);
    chk("midrst_third_issue", 32'(mem_rd_en), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("midrst_chip_en", 32'(mem_chip_en), 32'd0);
    chk("midrst_rdat_valid", 32'(rdat_valid), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    exp_done--;
    exp_rd.delete();
    exp_rl.delete();
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    chk("midrst_cmd_ready_after", 32'(cmd_ready), 32'd1);
    chk("midrst_rdat_valid_after", 32'(rdat_valid), 32'd0);
    run_cmd(1'b0, 'h010, 3);

    repeat (3) @(negedge clock);
    chk("done_total", 32'(done_cnt), 32'(exp_done));
    chk("err_total", 32'(err_cnt), 32'(exp_err));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
